// File: rtl/pkt_ram_read_pkg.sv
// Shared packet-buffer definitions: word tags, field widths and the read FSM encoding.
// Used by both the PCB write side and the egress reader.
package pkt_ram_read_pkg;

    localparam int BUFID_W = 9;
    localparam int OFS_W   = 7;
    localparam int DATA_W  = 134;
    localparam int ADDR_W  = BUFID_W + OFS_W;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [OFS_W-1:0] OFS_LAST = '1;

    typedef enum logic [2:0] {
        IDLE_S     = 3'd0,
        WAIT_ACK_S = 3'd1,
        RD_REQ_S   = 3'd2,
        RELEASE_S  = 3'd3
    } read_state_t;

    function automatic logic [1:0] word_tag(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 2];
    endfunction

    function automatic logic [DATA_W-1:0] force_tail(input logic [DATA_W-1:0] w);
        return {TAG_TAIL, w[DATA_W-3:0]};
    endfunction

endpackage

// File: rtl/pkt_ram_read_if.sv
// Signal bundle between the egress packet reader and its queue, PCB and output FIFO.
// PKT_RAM_READ_DEBUG_EN adds the two debug counter outputs.
interface pkt_ram_read_if;
    import pkt_ram_read_pkg::*;

    logic                 i_bufid_empty;
    logic [BUFID_W-1:0]   iv_bufid;
    logic                 o_bufid_ack;
    logic                 o_data_rd;
    logic [ADDR_W-1:0]    ov_data_raddr;
    logic                 i_rdata_ack;
    logic [DATA_W-1:0]    iv_rdata;
    logic [DATA_W-1:0]    ov_data;
    logic                 o_data_wr;
    logic                 i_fifo_afull;
    logic [BUFID_W-1:0]   ov_release_bufid;
    logic                 o_release_wr;
    logic                 o_overlen_err;
    logic [2:0]           ov_read_state;

`ifdef PKT_RAM_READ_DEBUG_EN
    logic [15:0]          ov_debug_pkt_cnt;
    logic [15:0]          ov_debug_overlen_cnt;

    modport master (
        input  i_bufid_empty, iv_bufid, i_rdata_ack, iv_rdata, i_fifo_afull,
        output o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
               ov_release_bufid, o_release_wr, o_overlen_err, ov_read_state,
               ov_debug_pkt_cnt, ov_debug_overlen_cnt
    );

    modport slave (
        output i_bufid_empty, iv_bufid, i_rdata_ack, iv_rdata, i_fifo_afull,
        input  o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
               ov_release_bufid, o_release_wr, o_overlen_err, ov_read_state,
               ov_debug_pkt_cnt, ov_debug_overlen_cnt
    );
`else
    modport master (
        input  i_bufid_empty, iv_bufid, i_rdata_ack, iv_rdata, i_fifo_afull,
        output o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
               ov_release_bufid, o_release_wr, o_overlen_err, ov_read_state
    );

    modport slave (
        output i_bufid_empty, iv_bufid, i_rdata_ack, iv_rdata, i_fifo_afull,
        input  o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
               ov_release_bufid, o_release_wr, o_overlen_err, ov_read_state
    );
`endif

endinterface

// File: rtl/pkt_ram_read_dbg.sv
// Debug counters for the egress reader: released packets and overlength packets.
// Only present when PKT_RAM_READ_DEBUG_EN is defined.
`ifdef PKT_RAM_READ_DEBUG_EN
module pkt_ram_read_dbg (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_release_wr,
    input  logic        i_overlen_err,
    output logic [15:0] ov_pkt_cnt,
    output logic [15:0] ov_overlen_cnt
);

    // Both counters wrap naturally at 16'hFFFF.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_pkt_cnt     <= 16'd0;
            ov_overlen_cnt <= 16'd0;
        end else begin
            if (i_release_wr) begin
                ov_pkt_cnt <= ov_pkt_cnt + 16'd1;
            end
            if (i_overlen_err) begin
                ov_overlen_cnt <= ov_overlen_cnt + 16'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/pkt_ram_read.sv
// Egress packet reader: pops a bufid, reads its words out of the PCB one at a time,
// forwards them to the output FIFO and releases the bufid. Option: PKT_RAM_READ_DEBUG_EN.
module pkt_ram_read
    import pkt_ram_read_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    pkt_ram_read_if.master bus
);

    read_state_t          state;
    read_state_t          state_nxt;

    logic [BUFID_W-1:0]   bufid_q;
    logic [BUFID_W-1:0]   bufid_d;
    logic [OFS_W-1:0]     ofs_q;
    logic [OFS_W-1:0]     ofs_d;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    data_d;
    logic                 data_wr_q;
    logic                 data_wr_d;
    logic                 data_rd_q;
    logic                 data_rd_d;
    logic                 bufid_ack_q;
    logic                 bufid_ack_d;
    logic [BUFID_W-1:0]   rel_bufid_q;
    logic [BUFID_W-1:0]   rel_bufid_d;
    logic                 rel_wr_q;
    logic                 rel_wr_d;
    logic                 overlen_q;
    logic                 overlen_d;

    logic                 start;
    logic                 tail_seen;
    logic                 last_ofs;

    assign start     = !bus.i_bufid_empty && !bus.i_fifo_afull;
    assign tail_seen = (word_tag(bus.iv_rdata) == TAG_TAIL);
    assign last_ofs  = (ofs_q == OFS_LAST);

    // All outputs are registered; reset clears data as well so nothing stale leaks after an abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE_S;
            bufid_q     <= '0;
            ofs_q       <= '0;
            data_q      <= '0;
            data_wr_q   <= 1'b0;
            data_rd_q   <= 1'b0;
            bufid_ack_q <= 1'b0;
            rel_bufid_q <= '0;
            rel_wr_q    <= 1'b0;
            overlen_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bufid_q     <= bufid_d;
            ofs_q       <= ofs_d;
            data_q      <= data_d;
            data_wr_q   <= data_wr_d;
            data_rd_q   <= data_rd_d;
            bufid_ack_q <= bufid_ack_d;
            rel_bufid_q <= rel_bufid_d;
            rel_wr_q    <= rel_wr_d;
            overlen_q   <= overlen_d;
        end
    end

    always_comb begin
        state_nxt = IDLE_S;
        case (state)
            IDLE_S: begin
                state_nxt = start ? WAIT_ACK_S : IDLE_S;
            end
            WAIT_ACK_S: begin
                if (!bus.i_rdata_ack) begin
                    state_nxt = WAIT_ACK_S;
                end else if (tail_seen || last_ofs) begin
                    state_nxt = RELEASE_S;
                end else begin
                    state_nxt = RD_REQ_S;
                end
            end
            RD_REQ_S: begin
                state_nxt = bus.i_fifo_afull ? RD_REQ_S : WAIT_ACK_S;
            end
            RELEASE_S: begin
                state_nxt = IDLE_S;
            end
            default: begin
                state_nxt = IDLE_S;
            end
        endcase
    end

    // Strobes default low so each one lasts a single cycle; addresses and data hold.
    always_comb begin
        bufid_d     = bufid_q;
        ofs_d       = ofs_q;
        data_d      = data_q;
        data_wr_d   = 1'b0;
        data_rd_d   = data_rd_q;
        bufid_ack_d = 1'b0;
        rel_bufid_d = rel_bufid_q;
        rel_wr_d    = 1'b0;
        overlen_d   = 1'b0;
        case (state)
            IDLE_S: begin
                data_rd_d = 1'b0;
                if (start) begin
                    bufid_d     = bus.iv_bufid;
                    ofs_d       = '0;
                    bufid_ack_d = 1'b1;
                    data_rd_d   = 1'b1;
                end
            end
            WAIT_ACK_S: begin
                if (bus.i_rdata_ack) begin
                    data_rd_d = 1'b0;
                    data_wr_d = 1'b1;
                    if (!tail_seen && last_ofs) begin
                        data_d    = force_tail(bus.iv_rdata);
                        overlen_d = 1'b1;
                    end else begin
                        data_d    = bus.iv_rdata;
                    end
                end
            end
            RD_REQ_S: begin
                if (!bus.i_fifo_afull) begin
                    ofs_d     = ofs_q + OFS_W'(1);
                    data_rd_d = 1'b1;
                end
            end
            RELEASE_S: begin
                rel_bufid_d = bufid_q;
                rel_wr_d    = 1'b1;
            end
            default: begin
                data_rd_d = 1'b0;
            end
        endcase
    end

    assign bus.o_bufid_ack      = bufid_ack_q;
    assign bus.o_data_rd        = data_rd_q;
    assign bus.ov_data_raddr    = {bufid_q, ofs_q};
    assign bus.ov_data          = data_q;
    assign bus.o_data_wr        = data_wr_q;
    assign bus.ov_release_bufid = rel_bufid_q;
    assign bus.o_release_wr     = rel_wr_q;
    assign bus.o_overlen_err    = overlen_q;
    assign bus.ov_read_state    = state;

`ifdef PKT_RAM_READ_DEBUG_EN
    pkt_ram_read_dbg u_dbg (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_release_wr   (rel_wr_q),
        .i_overlen_err  (overlen_q),
        .ov_pkt_cnt     (bus.ov_debug_pkt_cnt),
        .ov_overlen_cnt (bus.ov_debug_overlen_cnt)
    );
`endif

endmodule
